transmitter: RTL and testbench

TRANSMITTER -- requirements
Module: transmitter

---
 rtl/transmitter_pkg.sv | 33 +++
 rtl/transmitter_sync_fifo.sv | 60 ++++++
 rtl/transmitter.sv | 148 ++++++++++++++
 tb/tb_transmitter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/transmitter_pkg.sv
// -----------------------------------------------------------------------------
// defines -- shared types and constants for the frame transmitter.
//   header_t      : frame header {dst[47:0], src[47:0], length[15:0]}
//   HDR_BYTES     : number of header bytes put on the wire (6 + 6 + 2)
//   DEFAULT_DEPTH : default payload FIFO depth in bytes
//   state_t       : framing FSM state encoding
//   header_byte() : selects header byte idx, most significant byte first
// -----------------------------------------------------------------------------
package defines;

   localparam int HDR_BYTES     = 14;
   localparam int DEFAULT_DEPTH = 16;

   typedef struct packed {
      logic [47:0] dst;
      logic [47:0] src;
      logic [15:0] length;
   } header_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      PAY  = 2'd2
   } state_t;

   // Byte 0 is dst[47:40], byte 13 is length[7:0]. Only called with idx < 14.
   function automatic logic [7:0] header_byte(input header_t h, input logic [3:0] idx);
      logic [111:0] flat;
      flat = h;
      return 8'(flat >> (8 * (HDR_BYTES - 1 - int'(idx))));
   endfunction

endpackage

// File: rtl/transmitter_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo -- single-clock byte FIFO, show-ahead read (dout = oldest entry).
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   wr_en, din : push din; ignored when full unless a pop happens the same cycle
//   rd_en      : pop the oldest entry; ignored when empty
//   dout       : oldest entry, valid while !empty
//   full/empty : combinational from the occupancy count
// A push into an empty FIFO is not visible on dout until the next cycle.
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [7:0] din,
   input  logic       rd_en,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push;
   logic          pop;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign pop   = rd_en && !empty;
   // A pop frees a slot in the same cycle, so a write at full is still taken.
   assign push  = wr_en && (!full || pop);
   assign dout  = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/transmitter.sv
// -----------------------------------------------------------------------------
// transmitter -- serialises a 14-byte header followed by `length` payload bytes
// taken from an internal FIFO onto a byte-wide valid/ready stream.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   tx_header, tx_header_valid/ready: header input handshake
//   btx_wr_en, tx_data, btx_full   : payload FIFO write side
//   tx_axis_tdata, t_valid, t_last : registered output byte stream
//   t_ready                        : downstream accept
//
// Handshake rule for both streams: a transfer happens on a rising edge where
// valid and ready are both 1. Once t_valid is raised, tx_axis_tdata and t_last
// hold until that transfer; valid never depends on ready.
// -----------------------------------------------------------------------------
module transmitter
   import defines::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic       clk,
   input  logic       rst_n,
   input  header_t    tx_header,
   input  logic       tx_header_valid,
   output logic       tx_header_ready,
   input  logic       btx_wr_en,
   input  logic [7:0] tx_data,
   output logic       btx_full,
   output logic [7:0] tx_axis_tdata,
   output logic       t_valid,
   output logic       t_last,
   input  logic       t_ready
);

   state_t      state;
   header_t     hdr_q;
   logic [3:0]  idx;      // next header byte to load into the output register
   logic [15:0] rem;      // payload bytes still to pop for this frame
   logic        alive;    // low until the first edge after reset release

   logic        slot_free;
   logic        hdr_accept;
   logic        hdr_done;
   logic [15:0] pay_rem;
   logic        pop;
   logic [7:0]  fifo_dout;
   logic        fifo_empty;

   sync_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_en (btx_wr_en),
      .din   (tx_data),
      .rd_en (pop),
      .dout  (fifo_dout),
      .full  (btx_full),
      .empty (fifo_empty)
   );

   assign tx_header_ready = alive && (state == IDLE) && !t_valid;
   assign hdr_accept      = tx_header_valid && tx_header_ready;

   always_comb begin
      // Output register may be (re)loaded when empty or being drained now.
      slot_free = !t_valid || t_ready;
      // All 14 header bytes loaded; the last one leaves on this slot_free edge.
      hdr_done  = (state == HDR) && (idx == 4'(HDR_BYTES));
      // On the HDR->PAY edge the counter is not yet loaded, use length directly
      // so the first payload byte follows the last header byte without a gap.
      pay_rem   = hdr_done ? hdr_q.length : rem;
      pop       = slot_free && !fifo_empty && (pay_rem != 16'd0) &&
                  ((state == PAY) || hdr_done);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         hdr_q         <= '0;
         idx           <= '0;
         rem           <= '0;
         t_valid       <= 1'b0;
         t_last        <= 1'b0;
         tx_axis_tdata <= 8'h00;
         alive         <= 1'b0;
      end else begin
         alive <= 1'b1;
         case (state)
            IDLE: begin
               if (hdr_accept) begin
                  hdr_q         <= tx_header;
                  t_valid       <= 1'b1;
                  tx_axis_tdata <= tx_header.dst[47:40];
                  t_last        <= 1'b0;
                  idx           <= 4'd1;
                  state         <= HDR;
               end
            end
            HDR: begin
               if (slot_free) begin
                  if (!hdr_done) begin
                     t_valid       <= 1'b1;
                     tx_axis_tdata <= header_byte(hdr_q, idx);
                     t_last        <= (idx == 4'(HDR_BYTES - 1)) && (hdr_q.length == 16'd0);
                     idx           <= idx + 4'd1;
                  end else begin
                     idx <= '0;
                     if (hdr_q.length == 16'd0) begin
                        t_valid <= 1'b0;
                        t_last  <= 1'b0;
                        state   <= IDLE;
                     end else begin
                        state <= PAY;
                        if (pop) begin
                           t_valid       <= 1'b1;
                           tx_axis_tdata <= fifo_dout;
                           t_last        <= (hdr_q.length == 16'd1);
                           rem           <= hdr_q.length - 16'd1;
                        end else begin
                           t_valid <= 1'b0;
                           t_last  <= 1'b0;
                           rem     <= hdr_q.length;
                        end
                     end
                  end
               end
            end
            PAY: begin
               if (slot_free) begin
                  if (t_valid && t_last) begin
                     t_valid <= 1'b0;
                     t_last  <= 1'b0;
                     state   <= IDLE;
                  end else if (pop) begin
                     t_valid       <= 1'b1;
                     tx_axis_tdata <= fifo_dout;
                     t_last        <= (rem == 16'd1);
                     rem           <= rem - 16'd1;
                  end else begin
                     // FIFO ran dry mid-frame: bubble until a byte arrives.
                     t_valid <= 1'b0;
                     t_last  <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_transmitter.sv
// -----------------------------------------------------------------------------
// tb_transmitter -- self-checking bench for transmitter.
// Table-driven frames, hand-written corner sequences and randomized frames,
// all compared against a frame model built from the header/payload rules.
// -----------------------------------------------------------------------------
module tb_transmitter;
   import defines::*;

   localparam int DEPTH  = 16;
   localparam int BUDGET = 2000;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   header_t    tx_header = '0;
   logic       tx_header_valid = 1'b0;
   logic       tx_header_ready;
   logic       btx_wr_en = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       btx_full;
   logic [7:0] tx_axis_tdata;
   logic       t_valid;
   logic       t_last;
   logic       t_ready = 1'b0;

   always #5 clk = ~clk;

   transmitter #(.DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .tx_header       (tx_header),
      .tx_header_valid (tx_header_valid),
      .tx_header_ready (tx_header_ready),
      .btx_wr_en       (btx_wr_en),
      .tx_data         (tx_data),
      .btx_full        (btx_full),
      .tx_axis_tdata   (tx_axis_tdata),
      .t_valid         (t_valid),
      .t_last          (t_last),
      .t_ready         (t_ready)
   );

   // ---------------- scoreboard state ----------------
   logic [8:0] exp_q[$];   // {last, byte}
   logic [8:0] got_q[$];
   logic [7:0] pay_q[$];   // payload bytes of the current frame, push order
   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [47:0] dst;
      logic [47:0] src;
      logic [15:0] len;
      logic [7:0]  base;
      int          mode;        // 0: ready=1, 1: toggle, 2: random
      int          exp_count;
      logic [7:0]  exp_first;
      logic [7:0]  exp_last_byte;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic header_t mk_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] l);
      header_t h;
      h.dst = d;
      h.src = s;
      h.length = l;
      return h;
   endfunction

   // Wire order: dst bytes MSB first, then src MSB first, then length MSB first.
   function automatic logic [7:0] model_hdr_byte(input header_t h, input int i);
      if (i < 6)       return 8'(h.dst >> (8 * (5 - i)));
      else if (i < 12) return 8'(h.src >> (8 * (11 - i)));
      else             return 8'(h.length >> (8 * (13 - i)));
   endfunction

   task automatic build_exp(input header_t h);
      exp_q.delete();
      for (int i = 0; i < HDR_BYTES; i++)
         exp_q.push_back({(i == HDR_BYTES - 1) && (h.length == 16'd0), model_hdr_byte(h, i)});
      for (int j = 0; j < int'(h.length); j++)
         exp_q.push_back({j == int'(h.length) - 1, pay_q[j]});
   endtask

   // ---------------- driver tasks ----------------
   task automatic push_raw(input logic [7:0] b);
      btx_wr_en = 1'b1;
      tx_data   = b;
      tick();
      btx_wr_en = 1'b0;
   endtask

   task automatic preload(input int n);
      for (int i = 0; i < n; i++) push_raw(pay_q[i]);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      #2 rst_n = 1'b1;
      tick();
   endtask

   task automatic send_hdr(input header_t h);
      bit ok;
      ok = 1'b0;
      got_q.delete();
      tx_header       = h;
      tx_header_valid = 1'b1;
      for (int c = 0; c < 50; c++) begin
         if (tx_header_ready) begin
            tick();
            ok = 1'b1;
            break;
         end
         tick();
      end
      tx_header_valid = 1'b0;
      if (!ok) check("hdr_accept_timeout", 32'd0, 32'd1);
      check("first_byte_latency", {t_valid, tx_axis_tdata}, {1'b1, model_hdr_byte(h, 0)});
   endtask

   // late_from >= 0: push pay_q[late_from..] at random cycles while draining.
   // late_from == -2: hold a write of C0 every cycle (push-at-full test).
   task automatic drive(input int target, input int mode, input int late_from);
      bit ok;
      int li;
      logic pv, pr, pl;
      logic [7:0] pd;
      ok = 1'b0;
      li = late_from;
      for (int c = 0; c < BUDGET; c++) begin
         if (got_q.size() >= target) begin
            ok = 1'b1;
            break;
         end
         case (mode)
            0:       t_ready = 1'b1;
            1:       t_ready = ~t_ready;
            default: t_ready = ($urandom_range(0, 3) != 0);
         endcase
         if (late_from == -2) begin
            btx_wr_en = 1'b1;
            tx_data   = 8'hC0;
         end else if (li >= 0 && li < pay_q.size() && $urandom_range(0, 1) == 1) begin
            btx_wr_en = 1'b1;
            tx_data   = pay_q[li];
            li++;
         end else begin
            btx_wr_en = 1'b0;
         end
         pv = t_valid; pr = t_ready; pd = tx_axis_tdata; pl = t_last;
         if (t_valid && t_ready) got_q.push_back({t_last, tx_axis_tdata});
         tick();
         if (pv && !pr) check("stall_hold", {t_valid, t_last, tx_axis_tdata}, {1'b1, pl, pd});
      end
      btx_wr_en = 1'b0;
      t_ready   = 1'b0;
      if (!ok) check("drain_timeout", got_q.size(), target);
   endtask

   task automatic compare_stream(input string tag);
      int n;
      check({tag, "_count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ready_after"}, tx_header_ready, 1'b1);
      check({tag, "_valid_after"}, t_valid, 1'b0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      header_t h;
      int      seen;
      int      len;
      int      npre;

      vecs[0] = '{48'hAABBCCDDEEFF, 48'h112233445566, 16'd10, 8'hA0, 0, 24, 8'hAA, 8'hA9};
      vecs[1] = '{48'hAABBCCDDEEFF, 48'h112233445566, 16'd10, 8'hA0, 1, 24, 8'hAA, 8'hA9};
      vecs[2] = '{48'h0,            48'h0,            16'd0,  8'h00, 0, 14, 8'h00, 8'h00};
      vecs[3] = '{48'h0123456789AB, 48'hCDEF01234567, 16'd3,  8'h30, 2, 17, 8'h01, 8'h32};

      // Reset values while asserted, then ready on the first edge after release.
      tick();
      tick();
      check("rst_valid", t_valid, 1'b0);
      check("rst_last", t_last, 1'b0);
      check("rst_data", tx_axis_tdata, 8'h00);
      check("rst_full", btx_full, 1'b0);
      check("rst_ready", tx_header_ready, 1'b0);
      #2 rst_n = 1'b1;
      #1 check("ready_before_edge", tx_header_ready, 1'b0);
      tick();
      check("ready_first_edge", tx_header_ready, 1'b1);

      // Table-driven frames.
      for (int v = 0; v < 4; v++) begin
         pay_q.delete();
         for (int i = 0; i < int'(vecs[v].len); i++) pay_q.push_back(vecs[v].base + 8'(i));
         h = mk_hdr(vecs[v].dst, vecs[v].src, vecs[v].len);
         build_exp(h);
         preload(int'(vecs[v].len));
         send_hdr(h);
         check($sformatf("vec%0d_first", v), tx_axis_tdata, vecs[v].exp_first);
         drive(vecs[v].exp_count, vecs[v].mode, -1);
         compare_stream($sformatf("vec%0d", v));
         check($sformatf("vec%0d_total", v), got_q.size(), vecs[v].exp_count);
         if (got_q.size() > 0)
            check($sformatf("vec%0d_last", v), got_q[got_q.size() - 1], {1'b1, vecs[v].exp_last_byte});
         check_idle($sformatf("vec%0d", v));
      end

      // Underrun: 2 of 5 bytes preloaded, bubble, then the other 3 pushed.
      pay_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
      h = mk_hdr(48'h102030405060, 48'h708090A0B0C0, 16'd5);
      build_exp(h);
      preload(2);
      send_hdr(h);
      drive(HDR_BYTES + 2, 0, -1);
      seen = 0;
      t_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (t_valid) seen++;
         tick();
      end
      check("bubble_valid_cycles", seen, 0);
      drive(HDR_BYTES + 5, 0, 2);
      compare_stream("underrun");
      check_idle("underrun");

      // Overflow: 17 pushes into a 16-deep FIFO, the 17th is dropped.
      pay_q.delete();
      for (int i = 0; i < DEPTH; i++) pay_q.push_back(8'hD0 + 8'(i));
      for (int i = 0; i < DEPTH; i++) begin
         if (i == DEPTH - 1) check("full_at_15", btx_full, 1'b0);
         push_raw(pay_q[i]);
      end
      check("full_at_16", btx_full, 1'b1);
      push_raw(8'hEE);
      check("full_after_drop", btx_full, 1'b1);
      h = mk_hdr(48'hFEDCBA987654, 48'h0F1E2D3C4B5A, 16'(DEPTH));
      build_exp(h);
      send_hdr(h);
      drive(HDR_BYTES + DEPTH, 0, -1);
      compare_stream("overflow");
      check("empty_after_overflow", btx_full, 1'b0);
      seen = 0;
      for (int c = 0; c < 5; c++) begin
         if (t_valid) seen++;
         tick();
      end
      check("dropped_not_sent", seen, 0);

      // Push while full and popping: the write lands in the freed slot.
      pay_q.delete();
      for (int i = 0; i < DEPTH; i++) pay_q.push_back(8'hE0 + 8'(i));
      pay_q.push_back(8'hC0);
      preload(DEPTH);
      h = mk_hdr(48'h1, 48'h2, 16'(DEPTH + 1));
      build_exp(h);
      send_hdr(h);
      drive(HDR_BYTES + DEPTH + 1, 0, -2);
      compare_stream("push_at_full");
      check("full_kept", btx_full, 1'b1);
      #2 rst_n = 1'b0;
      #1 check("async_rst_full", btx_full, 1'b0);
      tick();
      #2 rst_n = 1'b1;
      tick();

      // Reset during payload byte 3, then a fresh 1-byte frame.
      pay_q.delete();
      for (int i = 0; i < 10; i++) pay_q.push_back(8'h90 + 8'(i));
      preload(10);
      h = mk_hdr(48'hAABBCCDDEEFF, 48'h112233445566, 16'd10);
      send_hdr(h);
      drive(HDR_BYTES + 2, 0, -1);
      check("pay3_on_bus", {t_valid, t_last, tx_axis_tdata}, {2'b10, 8'h92});
      #2 rst_n = 1'b0;
      #1;
      check("midrst_valid", t_valid, 1'b0);
      check("midrst_last", t_last, 1'b0);
      check("midrst_data", tx_axis_tdata, 8'h00);
      check("midrst_full", btx_full, 1'b0);
      check("midrst_ready", tx_header_ready, 1'b0);
      tick();
      #2 rst_n = 1'b1;
      tick();
      check("midrst_ready_after", tx_header_ready, 1'b1);
      pay_q = '{8'h55};
      h = mk_hdr(48'h0A0B0C0D0E0F, 48'h010203040506, 16'd1);
      build_exp(h);
      preload(1);
      send_hdr(h);
      drive(HDR_BYTES + 1, 0, -1);
      compare_stream("post_reset");
      check_idle("post_reset");

      // Randomized frames with random preload, late pushes and backpressure.
      for (int f = 0; f < 6; f++) begin
         len  = $urandom_range(1, DEPTH);
         npre = $urandom_range(0, len);
         pay_q.delete();
         for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom));
         h = mk_hdr({16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)}, 16'(len));
         build_exp(h);
         preload(npre);
         send_hdr(h);
         drive(HDR_BYTES + len, 2, npre);
         compare_stream($sformatf("rand%0d", f));
         check_idle($sformatf("rand%0d", f));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
